pe_arr_ctrl: RTL and testbench

//   Job sequencer for the 2-D PE array (PE_ARR_SIZE MACs + bias, fixed pipeline, no stall input).

---
 rtl/pe_arr_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pe_arr_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_arr_ctrl.sv
// Job sequencer for the PE array: loads one weight/bias set, streams IFM windows,
// tracks in-flight results with a tag pipeline and buffers them in a credit-limited FIFO.
module pe_arr_ctrl #(
  parameter int INPUT_IFM_WIDTH  = 8,
  parameter int INPUT_WGT_WIDTH  = 8,
  parameter int INPUT_BIAS_WIDTH = 8,
  parameter int OUTPUT_WIDTH     = 20,
  parameter int PE_ARR_SIZE      = 9,
  parameter int PE_LATENCY       = 5,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [15:0]                            cfg_num_win,
  output logic                                   busy,
  output logic                                   done,
  input  logic                                   wgt_valid,
  output logic                                   wgt_ready,
  input  logic [PE_ARR_SIZE*INPUT_WGT_WIDTH-1:0] wgt_data,
  input  logic [INPUT_BIAS_WIDTH-1:0]            bias_data,
  input  logic                                   win_valid,
  output logic                                   win_ready,
  input  logic [PE_ARR_SIZE*INPUT_IFM_WIDTH-1:0] win_data,
  output logic [PE_ARR_SIZE*INPUT_IFM_WIDTH-1:0] pe_ifm,
  output logic [PE_ARR_SIZE*INPUT_WGT_WIDTH-1:0] pe_wgt,
  output logic [INPUT_BIAS_WIDTH-1:0]            pe_bias,
  input  logic [OUTPUT_WIDTH-1:0]                pe_ofm,
  output logic                                   ofm_valid,
  input  logic                                   ofm_ready,
  output logic [OUTPUT_WIDTH-1:0]                ofm_data,
  output logic                                   ofm_last
);

  localparam int IFM_W  = PE_ARR_SIZE * INPUT_IFM_WIDTH;
  localparam int WGT_W  = PE_ARR_SIZE * INPUT_WGT_WIDTH;
  localparam int STAGES = PE_LATENCY + 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic                    last;
    logic [OUTPUT_WIDTH-1:0] data;
  } ofm_ent_t;

  state_e                  state_q, state_d;
  logic [15:0]             num_win_q, num_win_d;
  logic [15:0]             issue_cnt_q, issue_cnt_d;
  logic [STAGES:1]         vld_pipe_q, vld_pipe_d;
  logic [STAGES:1]         last_pipe_q, last_pipe_d;
  logic [CNT_W-1:0]        occ_q, occ_d;
  logic [CNT_W-1:0]        fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  ofm_ent_t                mem_q [FIFO_DEPTH];
  ofm_ent_t                mem_d [FIFO_DEPTH];
  logic [IFM_W-1:0]        pe_ifm_q, pe_ifm_d;
  logic [WGT_W-1:0]        pe_wgt_q, pe_wgt_d;
  logic [INPUT_BIAS_WIDTH-1:0] pe_bias_q, pe_bias_d;

  logic                    win_hs, wgt_hs, push, pop, issue_last;
  logic [CNT_W-1:0]        occ_net;
  ofm_ent_t                head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign wgt_ready = (state_q == S_LOAD);

  // occ_q counts every result from issue until it is popped, so a pop this
  // cycle frees its slot for an issue in the same cycle.
  assign pop        = ofm_valid & ofm_ready;
  assign occ_net    = occ_q - CNT_W'(pop);
  assign win_ready  = (state_q == S_RUN) && (occ_net < CNT_W'(FIFO_DEPTH));
  assign win_hs     = win_valid & win_ready;
  assign wgt_hs     = wgt_valid & wgt_ready;
  assign push       = vld_pipe_q[STAGES];
  assign issue_last = (issue_cnt_q == num_win_q - 16'd1);

  assign head      = mem_q[rd_ptr_q];
  assign ofm_valid = (fifo_cnt_q != '0);
  assign ofm_data  = ofm_valid ? head.data : '0;
  assign ofm_last  = ofm_valid & head.last;

  assign pe_ifm  = pe_ifm_q;
  assign pe_wgt  = pe_wgt_q;
  assign pe_bias = pe_bias_q;

  always_comb begin
    state_d     = state_q;
    num_win_d   = num_win_q;
    issue_cnt_d = issue_cnt_q;
    pe_ifm_d    = pe_ifm_q;
    pe_wgt_d    = pe_wgt_q;
    pe_bias_d   = pe_bias_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_win_d   = cfg_num_win;
          issue_cnt_d = '0;
          state_d     = (cfg_num_win == 16'd0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (wgt_hs) begin
          pe_wgt_d  = wgt_data;
          pe_bias_d = bias_data;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (win_hs) begin
          pe_ifm_d    = win_data;
          issue_cnt_d = issue_cnt_q + 16'd1;
          if (issue_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (occ_q == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Tag pipeline: stage 1 is loaded on the issue handshake, the result is
  // captured from pe_ofm when the tag leaves the last stage.
  always_comb begin
    vld_pipe_d     = '0;
    last_pipe_d    = '0;
    vld_pipe_d[1]  = win_hs;
    last_pipe_d[1] = win_hs & issue_last;
    for (int k = 2; k <= STAGES; k++) begin
      vld_pipe_d[k]  = vld_pipe_q[k-1];
      last_pipe_d[k] = last_pipe_q[k-1];
    end
    occ_d      = occ_q + CNT_W'(win_hs) - CNT_W'(pop);
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{last: last_pipe_q[STAGES], data: pe_ofm};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      num_win_q   <= '0;
      issue_cnt_q <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      occ_q       <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pe_ifm_q    <= '0;
      pe_wgt_q    <= '0;
      pe_bias_q   <= '0;
    end else begin
      state_q     <= state_d;
      num_win_q   <= num_win_d;
      issue_cnt_q <= issue_cnt_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      occ_q       <= occ_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pe_ifm_q    <= pe_ifm_d;
      pe_wgt_q    <= pe_wgt_d;
      pe_bias_q   <= pe_bias_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_pe_arr_ctrl.sv
// Scoreboard bench for pe_arr_ctrl: behavioural PE array model, expected results
// queued at window issue, popped and compared by an independent output monitor.
module tb_pe_arr_ctrl;
  localparam int IW = 8, WW = 8, BW = 8, OW = 20, N = 9, LAT = 5, FD = 8;
  localparam int IFM_W = N * IW;
  localparam int WGT_W = N * WW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [15:0]      cfg_num_win = '0;
  logic             busy, done, wgt_ready, win_ready;
  logic             wgt_valid = 1'b0;
  logic [WGT_W-1:0] wgt_data = '0;
  logic [BW-1:0]    bias_data = '0;
  logic             win_valid = 1'b0;
  logic [IFM_W-1:0] win_data = '0;
  logic [IFM_W-1:0] pe_ifm;
  logic [WGT_W-1:0] pe_wgt;
  logic [BW-1:0]    pe_bias;
  logic [OW-1:0]    pe_ofm;
  logic             ofm_valid, ofm_last;
  logic             ofm_ready = 1'b0;
  logic [OW-1:0]    ofm_data;

  pe_arr_ctrl #(
    .INPUT_IFM_WIDTH(IW), .INPUT_WGT_WIDTH(WW), .INPUT_BIAS_WIDTH(BW),
    .OUTPUT_WIDTH(OW), .PE_ARR_SIZE(N), .PE_LATENCY(LAT), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_num_win(cfg_num_win),
    .busy(busy), .done(done),
    .wgt_valid(wgt_valid), .wgt_ready(wgt_ready), .wgt_data(wgt_data), .bias_data(bias_data),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .pe_ifm(pe_ifm), .pe_wgt(pe_wgt), .pe_bias(pe_bias), .pe_ofm(pe_ofm),
    .ofm_valid(ofm_valid), .ofm_ready(ofm_ready), .ofm_data(ofm_data), .ofm_last(ofm_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_chk = 0, n_fail = 0;
  int done_cnt = 0, res_cnt = 0, wgt_hs_cnt = 0, win_hs_cnt = 0;
  int done0, res0, job_nwin, iss_idx;
  int unsigned ready_pct = 100, vpct = 100;
  bit prev_done = 0, hs = 0, fixed_win = 0;
  logic [OW-1:0]    last_data;
  logic             last_flag;
  logic [WGT_W-1:0] job_wgt;
  logic [BW-1:0]    job_bias;
  logic [IFM_W-1:0] w19;

  function automatic logic [OW-1:0] dot(input logic [IFM_W-1:0] x,
                                         input logic [WGT_W-1:0] w,
                                         input logic [BW-1:0] b);
    int s = int'(b);
    for (int i = 0; i < N; i++) s += int'(x[i*IW +: IW]) * int'(w[i*WW +: WW]);
    return OW'(s);
  endfunction

  function automatic logic [IFM_W-1:0] gen_win();
    logic [IFM_W-1:0] x;
    if (fixed_win) return w19;
    for (int i = 0; i < N; i++) x[i*IW +: IW] = IW'($urandom_range(255));
    return x;
  endfunction

  function automatic logic [WGT_W-1:0] rand_wgt();
    logic [WGT_W-1:0] w;
    for (int i = 0; i < N; i++) w[i*WW +: WW] = WW'($urandom_range(255));
    return w;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // PE array model: result of the current pe_* drive appears LAT cycles later.
  logic [OW-1:0] pe_pipe [LAT];
  always @(posedge clk) begin
    pe_pipe[0] <= dot(pe_ifm, pe_wgt, pe_bias);
    for (int k = 1; k < LAT; k++) pe_pipe[k] <= pe_pipe[k-1];
  end
  assign pe_ofm = pe_pipe[LAT-1];

  always @(posedge clk) begin
    #1;
    ofm_ready = ($urandom_range(99) < ready_pct);
  end

  // Output monitor
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 0;
    end else begin
      if (wgt_valid && wgt_ready) wgt_hs_cnt++;
      if (win_valid && win_ready) win_hs_cnt++;
      if (prev_done) begin
        chk("busy_falls_after_done", busy, 1'b0);
        chk("done_single_cycle", done, 1'b0);
      end
      if (done) begin
        done_cnt++;
        chk("busy_during_done", busy, 1'b1);
      end
      prev_done = done;
      if (ofm_valid && ofm_ready) begin
        res_cnt++;
        last_data = ofm_data;
        last_flag = ofm_last;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_result: got 0x%0h expected none", ofm_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ofm_data", ofm_data, mon_e.data);
          chk("ofm_last", ofm_last, mon_e.last);
        end
      end
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_wgt_ready"}, wgt_ready, 1'b0);
    chk({tag, "_win_ready"}, win_ready, 1'b0);
    chk({tag, "_ofm_valid"}, ofm_valid, 1'b0);
    chk({tag, "_ofm_data"}, ofm_data, '0);
    chk({tag, "_ofm_last"}, ofm_last, 1'b0);
    chk({tag, "_pe_ifm"}, pe_ifm, '0);
    chk({tag, "_pe_wgt"}, pe_wgt, '0);
    chk({tag, "_pe_bias"}, pe_bias, '0);
  endtask

  task automatic start_job(input int nwin, input logic [WGT_W-1:0] w, input logic [BW-1:0] b);
    int c = 0;
    job_wgt = w; job_bias = b; job_nwin = nwin; iss_idx = 0;
    res0 = res_cnt; done0 = done_cnt;
    @(posedge clk); #1;
    start = 1; cfg_num_win = 16'(nwin);
    @(posedge clk); #1;
    start = 0; cfg_num_win = 16'($urandom);
    wgt_valid = 1; wgt_data = w; bias_data = b;
    @(negedge clk);
    while (!wgt_ready && c < 50) begin @(negedge clk); c++; end
    chk("wgt_accepted", wgt_ready, 1'b1);
    @(posedge clk); #1;
    wgt_valid = 0;
    chk("pe_wgt_loaded", pe_wgt, w);
    chk("pe_bias_loaded", pe_bias, b);
  endtask

  task automatic issue_windows(input int target, input int max_cyc, output int cyc);
    cyc = 0; hs = 0;
    while (iss_idx < target && cyc < max_cyc) begin
      @(posedge clk); #1;
      cyc++;
      if (hs) win_valid = 0;
      hs = 0;
      if (!win_valid && ($urandom_range(99) < vpct)) begin
        win_valid = 1;
        win_data  = gen_win();
      end
      @(negedge clk);
      if (win_valid && win_ready) begin
        hs = 1;
        exp_q.push_back('{data: dot(win_data, job_wgt, job_bias), last: (iss_idx == job_nwin - 1)});
        iss_idx++;
      end
    end
    @(posedge clk); #1;
    win_valid = 0; hs = 0;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (done_cnt == done0 && c < budget) begin @(posedge clk); #1; c++; end
    repeat (2) @(posedge clk);
    #1;
    chk("job_done_once", done_cnt - done0, 1);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("result_count", res_cnt - res0, job_nwin);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, busy_cyc, done_at, w0, i0;
    for (int i = 0; i < N; i++) w19[i*IW +: IW] = IW'(i + 1);

    // Reset state
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    rst = 0;

    // 1: single window, weights/window 1..9, bias 1
    fixed_win = 1; vpct = 100; ready_pct = 100;
    start_job(1, w19, 8'd1);
    issue_windows(1, 50, cyc);
    wait_done(200);
    chk("t1_ofm_286", last_data, 20'd286);
    chk("t1_ofm_last", last_flag, 1'b1);
    fixed_win = 0;

    // 2: 16 windows at full rate
    start_job(16, rand_wgt(), 8'($urandom));
    issue_windows(16, 100, cyc);
    chk("t2_consecutive_issue_cycles", cyc, 16);
    wait_done(300);

    // 3: consumer stalled, credit limit
    ready_pct = 0;
    start_job(12, rand_wgt(), 8'($urandom));
    issue_windows(12, 40, cyc);
    chk("t3_accepted_while_stalled", iss_idx, 8);
    chk("t3_win_ready_low", win_ready, 1'b0);
    ready_pct = 100;
    issue_windows(12, 300, cyc);
    wait_done(300);

    // 4: zero-window job with stray valids
    w0 = wgt_hs_cnt; i0 = win_hs_cnt; done0 = done_cnt;
    busy_cyc = 0; done_at = -1;
    @(posedge clk); #1;
    start = 1; cfg_num_win = 16'd0;
    wgt_valid = 1; win_valid = 1; win_data = gen_win();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done && done_at < 0) done_at = k;
      @(posedge clk); #1;
      start = 0;
    end
    wgt_valid = 0; win_valid = 0;
    chk("t4_done_once", done_cnt - done0, 1);
    chk("t4_no_wgt_handshake", wgt_hs_cnt - w0, 0);
    chk("t4_no_win_handshake", win_hs_cnt - i0, 0);
    chk("t4_busy_short", (busy_cyc >= 1 && busy_cyc <= 2), 1'b1);
    chk("t4_done_latency", (done_at >= 1 && done_at <= 2), 1'b1);

    // 5: reset mid-run with results in flight, then a clean job
    ready_pct = 0;
    start_job(10, rand_wgt(), 8'($urandom));
    issue_windows(3, 50, cyc);
    rst = 1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 0;
    chk_idle("t5_after_rst");
    ready_pct = 100; fixed_win = 1;
    start_job(1, w19, 8'd1);
    issue_windows(1, 50, cyc);
    wait_done(200);
    chk("t5_ofm_286", last_data, 20'd286);
    fixed_win = 0;

    // 6: start pulse during RUN is ignored
    start_job(5, rand_wgt(), 8'($urandom));
    issue_windows(2, 50, cyc);
    start = 1; cfg_num_win = 16'd99;
    @(posedge clk); #1;
    start = 0;
    issue_windows(5, 100, cyc);
    wait_done(300);

    // Randomized jobs with random valid/ready duty cycles
    for (int j = 0; j < 6; j++) begin
      int nw;
      nw        = $urandom_range(1, 20);
      vpct      = $urandom_range(30, 100);
      ready_pct = $urandom_range(20, 100);
      start_job(nw, rand_wgt(), 8'($urandom));
      issue_windows(nw, 2000, cyc);
      wait_done(2000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
